// File: rtl/cmult_pkg.sv
// Shared constants and types for the Q1.15 complex-multiplier datapath.
package cmult_pkg;

    localparam int unsigned WORD_SIZE = 16;
    localparam int unsigned CMULT_LAT = 3;

    typedef struct packed {
        logic signed [WORD_SIZE-1:0] re;
        logic signed [WORD_SIZE-1:0] im;
    } cplx_t;

    localparam logic [WORD_SIZE-1:0] ONE_HALF = 16'h4000;
    localparam logic [WORD_SIZE-1:0] ROUND    = 16'h4000;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: pointer register plus combinational grant search.
// Optional macro CMULT_ARB_PRIO0_EN gives requester 0 absolute priority.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [IDXW-1:0] grant_c,
    output logic [NREQ-1:0] gnt_oh_c,
    output logic            any_c
);

    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] cand;
    logic [IDXW-1:0] rr_grant;
    logic            rr_found;
    logic [NREQ-1:0] rr_req;

    // Requester 0 is excluded from the rotation when it has fixed priority.
    always_comb begin
        rr_req = req;
`ifdef CMULT_ARB_PRIO0_EN
        rr_req[0] = 1'b0;
`endif
    end

    // First requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        cand     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDXW'((32'(ptr_q) + k) % NREQ);
            if (!rr_found && rr_req[cand]) begin
                rr_found = 1'b1;
                rr_grant = cand;
            end
        end
    end

    always_comb begin
        any_c    = |req;
        grant_c  = rr_grant;
        ptr_d    = ptr_q;
`ifdef CMULT_ARB_PRIO0_EN
        if (req[0]) begin
            grant_c = '0;
        end else if (rr_found) begin
            ptr_d = IDXW'((32'(rr_grant) + 32'd1) % NREQ);
        end
`else
        if (rr_found) begin
            ptr_d = IDXW'((32'(rr_grant) + 32'd1) % NREQ);
        end
`endif
        gnt_oh_c = any_c ? (NREQ'(1) << grant_c) : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cmult_arbiter.sv
// Shares one pipelined complex multiplier among NREQ requesters and routes
// products back by tag. Macro CMULT_ARB_PRIO0_EN selects fixed priority for requester 0.
module cmult_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WORD_SIZE = cmult_pkg::WORD_SIZE,
    parameter int unsigned LAT       = cmult_pkg::CMULT_LAT,
    parameter int unsigned IDXW      = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*2*WORD_SIZE-1:0] req_a,
    input  logic [NREQ*2*WORD_SIZE-1:0] req_b,
    output logic [NREQ-1:0]             rsp_valid,
    output logic [2*WORD_SIZE-1:0]      rsp_data,
    output logic                        m_valid,
    output logic [2*WORD_SIZE-1:0]      m_a,
    output logic [2*WORD_SIZE-1:0]      m_b,
    input  logic                        m_o_valid,
    input  logic [2*WORD_SIZE-1:0]      m_c,
    output logic                        busy,
    output logic                        err
);

    localparam int unsigned CW = 2 * WORD_SIZE;

    logic [IDXW-1:0] grant;
    logic [NREQ-1:0] gnt_oh;
    logic            any_req;
    logic            issue;

    logic [LAT-1:0]            tag_v_q, tag_v_d;
    logic [LAT-1:0][IDXW-1:0]  tag_idx_q, tag_idx_d;
    logic [NREQ-1:0]           rsp_valid_q, rsp_valid_d;
    logic [CW-1:0]             rsp_data_q, rsp_data_d;
    logic                      err_q, err_d;
    logic                      head_v;
    logic [IDXW-1:0]           head_idx;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr (
        .clk      (clk),
        .reset    (reset),
        .req      (req_valid),
        .grant_c  (grant),
        .gnt_oh_c (gnt_oh),
        .any_c    (any_req)
    );

    // Nothing is accepted while reset is held.
    always_comb begin
        issue     = any_req & reset;
        req_ready = issue ? gnt_oh : '0;
        m_valid   = issue;
    end

    always_comb begin
        m_a = '0;
        m_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (issue && gnt_oh[i]) begin
                m_a = req_a[i*CW +: CW];
                m_b = req_b[i*CW +: CW];
            end
        end
    end

    // Tag delay line; the head lines up with the multiplier's o_valid.
    always_comb begin
        tag_v_d      = '0;
        tag_idx_d    = '0;
        tag_v_d[0]   = issue;
        tag_idx_d[0] = grant;
        for (int unsigned i = 1; i < LAT; i++) begin
            tag_v_d[i]   = tag_v_q[i-1];
            tag_idx_d[i] = tag_idx_q[i-1];
        end
    end

    always_comb begin
        head_v      = tag_v_q[LAT-1];
        head_idx    = tag_idx_q[LAT-1];
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        err_d       = err_q | (head_v != m_o_valid);
        if (head_v && m_o_valid) begin
            rsp_valid_d = NREQ'(1) << head_idx;
            rsp_data_d  = m_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_v_q     <= '0;
            tag_idx_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            tag_v_q     <= tag_v_d;
            tag_idx_q   <= tag_idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign err       = err_q;
    assign busy      = (|tag_v_q) | (|rsp_valid_q);

endmodule

// File: doc/cmult_arbiter.md
Name: cmult_arbiter

Overview:
- Shares one 3-stage Q1.15 complex multiplier pipeline among NREQ requesters, e.g. the butterfly stages of the FFT core that need twiddle multiplies.
- Round-robin arbitrates one operand pair per cycle into the multiplier.
- Tracks each in-flight issue with a requester tag in a delay line matched to multiplier latency.
- Routes each product back to the requester that issued it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WORD_SIZE, 16, bits per real/imag component.
- LAT, 3, multiplier latency in cycles, i_valid to o_valid.
- IDXW, $clog2(NREQ), tag width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*2*WORD_SIZE  packed operand A per requester; requester i in slice i; {re,im} within each slice.
- req_b  in  NREQ*2*WORD_SIZE  packed operand B, same packing as req_a.
- rsp_valid  out  NREQ  one-hot strobe marking the owner of rsp_data.
- rsp_data  out  2*WORD_SIZE  product {re,im}, shared by all requesters.
- m_valid  out  1  to multiplier i_valid.
- m_a  out  2*WORD_SIZE  to multiplier A.
- m_b  out  2*WORD_SIZE  to multiplier B.
- m_o_valid  in  1  from multiplier o_valid.
- m_c  in  2*WORD_SIZE  from multiplier C.
- busy  out  1  high while any issue is in flight.
- err  out  1  sticky: m_o_valid disagreed with the tag pipe.

Behaviour:
- Arbitration (combinational):
  - grant = first i with req_valid[i], searched from ptr upward, wrapping modulo NREQ.
  - req_ready = onehot(grant) if any req_valid is high, else 0.
  - Handshake: issue occurs when req_valid[i] && req_ready[i].
  - Requesters must hold req_valid and operands stable until accepted.
- Issue (combinational drive into the registered multiplier):
  - m_valid = |req_valid.
  - m_a / m_b = mux of the granted slices.
  - When m_valid is 0, m_a / m_b = 0.
- Pointer:
  - Register, reset value 0.
  - On an issue, ptr <= (grant+1) mod NREQ.
  - Otherwise ptr holds.
- Tag pipe:
  - LAT-entry shift register of {v, idx}.
  - Entry 0 loads {issue, grant} every cycle.
  - Entries shift one place per cycle.
  - Head entry = entry LAT-1, aligned with m_o_valid.
- Response (registered, 1 cycle after m_o_valid):
  - If the head v && m_o_valid: rsp_valid <= onehot(head idx), rsp_data <= m_c.
  - Otherwise rsp_valid <= 0 and rsp_data holds.
  - Total latency from issue to rsp_valid is LAT+1 = 4 cycles.
  - There is no response backpressure; requesters must sink rsp in the cycle it is valid.
- err:
  - Set when head v != m_o_valid.
  - Cleared only by reset.
  - Responses are still produced for head v && m_o_valid.
- busy = OR of all tag v bits OR |rsp_valid.
- Throughput: 1 issue per cycle sustained.
  - With all NREQ requesting continuously, grants cycle 0,1,2,3,0…
  - No requester waits more than NREQ-1 cycles.
- Boundary conditions:
  - No requests: ptr holds, m_valid 0.
  - Single requester continuously valid: granted every cycle.
  - ptr = NREQ-1 wraps to 0.
  - Issue and response in the same cycle are independent.
- Reset (active, reset == 0):
  - ptr, tag pipe, rsp_valid, rsp_data and err all clear to 0; req_ready = 0.
  - In-flight products are discarded. The multiplier is reset by the same net, so no stray o_valid occurs.
  - Reset asserted mid-operation behaves the same; no response is emitted for pre-reset issues.

Optional Feature:
- Macro CMULT_ARB_PRIO0_EN.
- Defined: requester 0 has fixed absolute priority. When req_valid[0] is high it wins regardless of ptr, and ptr is not updated. Requesters 1..NREQ-1 round-robin among themselves when req_valid[0] is low.
- Undefined: pure round-robin over all NREQ as above.

Decomposition:
- Package cmult_pkg:
  - WORD_SIZE, CMULT_LAT = 3.
  - cplx_t typedef (packed {re,im} of WORD_SIZE signed).
  - Q15 constants ONE_HALF = 16'h4000, ROUND = 16'h4000.
- Sub-module rr_arbiter:
  - Parameterised on NREQ.
  - Contains the pointer register and the grant/onehot logic.
  - Reused by other FFT shared-resource controllers.
- The arbiter top holds the operand mux, the tag pipe and the response register.

Test Plan:
- Single issue: reset then reset=1; req0 with A=32'h4000_0000, B=32'h4000_0000 accepted at cycle t → rsp_valid=4'b0001 at t+4, rsp_data=32'h2000_0000; busy high t..t+4; err stays 0.
- Full contention: all 4 requesters held valid, with A=32'h4000_0000 and B distinct per requester (e.g. 32'h2000_0000, 32'h1000_0000, 32'h0800_0000, 32'h0400_0000) so products differ → grants 0,1,2,3,0 on consecutive cycles; rsp_valid sequence 0001,0010,0100,1000 starting 4 cycles after the first issue; each rsp_data equals the product of that requester's operands.
- Wrap and idle: only req3 valid, then only req1 → grant 3, then ptr=0, and req1 is granted next; with no requests, m_valid=0 and ptr is unchanged.
- Complex product: A=32'h4000_4000 (0.5+0.5j), B=32'h0000_4000 (0.5j) → rsp_data=32'hE000_2000 (-0.25+0.25j).
- Reset mid-flight: issue 3 back-to-back, assert reset for 1 cycle at issue+1 → no rsp_valid ever asserted for them; busy=0 after reset; the next issue completes normally.
- Tag mismatch: force m_o_valid high with an empty tag pipe → err=1 and stays high; rsp_valid stays 0; err clears only on reset.
